// File: rtl/instruction_decode_pkg.sv
// Shared opcode/funct encodings and control bundle for the ID stage.
// Optional debug read port on the register file: DEBUG_REGFILE_EN.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [1:0] BHW_BYTE = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_WORD = 2'b11;

  typedef struct packed {
    logic       wb_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       mem_unsigned;
    logic [1:0] bhw;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [1:0] bhw_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: bhw_of = BHW_BYTE;
      OP_LH, OP_LHU, OP_SH: bhw_of = BHW_HALF;
      default:              bhw_of = BHW_WORD;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file, two bypassed read ports, one write port.
// Optional debug read port: DEBUG_REGFILE_EN.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_ADDR-1:0] raddr_a,
  input  logic [NB_ADDR-1:0] raddr_b,
  output logic [NB_DATA-1:0] rdata_a,
  output logic [NB_DATA-1:0] rdata_b
`ifdef DEBUG_REGFILE_EN
  ,
  input  logic [NB_ADDR-1:0] debug_addr,
  output logic [NB_DATA-1:0] debug_data
`endif
);

  logic [NB_DATA-1:0] regs [N_REGS];
  logic               wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++)
        regs[i] <= NB_DATA'(i);
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // WB writes in the same cycle are forwarded to the readers
  assign rdata_a = (wr_ok && waddr == raddr_a) ? wdata
                 : regs[raddr_a];
  assign rdata_b = (wr_ok && waddr == raddr_b) ? wdata
                 : regs[raddr_b];

`ifdef DEBUG_REGFILE_EN
  assign debug_data = regs[debug_addr];
`endif

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: decode, regfile read, jump/branch resolve, ID/EX regs.
// Optional debug port on the register file: DEBUG_REGFILE_EN.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [31:0]        i_instruction,
  input  logic               i_write_enable_WB,
  input  logic [NB_ADDR-1:0] i_register_WB,
  input  logic [NB_DATA-1:0] i_data_WB,
  input  logic               i_stall,
  output logic [NB_DATA-1:0] o_RA,
  output logic [NB_DATA-1:0] o_RB,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [NB_ADDR-1:0] o_shamt,
  output logic [5:0]         o_funct,
  output logic [5:0]         o_opcode,
  output logic [15:0]        o_inmediato,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic               o_MEM_read,
  output logic               o_MEM_write,
  output logic               o_MEM_unsigned,
  output logic [1:0]         o_MEM_byte_half_word,
  output logic               o_EX_alu_src,
  output logic               o_EX_reg_dst,
  output logic [1:0]         o_EX_alu_op,
  output logic [NB_DATA-1:0] o_jump_addr,
  output logic               o_jump,
  output logic               o_halt
`ifdef DEBUG_REGFILE_EN
  ,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data
`endif
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode = i_instruction[31:26];
  assign rs     = i_instruction[25:21];
  assign rt     = i_instruction[20:16];
  assign rd     = i_instruction[15:11];
  assign shamt  = i_instruction[10:6];
  assign funct  = i_instruction[5:0];
  assign imm    = i_instruction[15:0];

  logic [NB_DATA-1:0] rs_data;
  logic [NB_DATA-1:0] rt_data;

  register_file #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .N_REGS  (N_REGS)
  ) u_regfile (
    .clk     (i_clk),
    .rst     (i_reset),
    .we      (i_write_enable_WB),
    .waddr   (i_register_WB),
    .wdata   (i_data_WB),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
`ifdef DEBUG_REGFILE_EN
    ,
    .debug_addr (i_debug_addr),
    .debug_data (o_debug_data)
`endif
  );

  logic r_type;
  logic is_r_alu, is_jr, is_jalr;
  logic is_ialu, is_load, is_store;
  logic is_j, is_jal, is_beq, is_bne;
  logic is_halt;

  assign r_type   = opcode == OP_RTYPE;
  assign is_r_alu = r_type && (funct inside {
                      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT,
                      FN_SLL, FN_SRL, FN_SRA,
                      FN_SLLV, FN_SRLV, FN_SRAV});
  assign is_jr    = r_type && funct == FN_JR;
  assign is_jalr  = r_type && funct == FN_JALR;
  assign is_ialu  = opcode inside {OP_ADDI, OP_ANDI, OP_ORI,
                                   OP_XORI, OP_LUI, OP_SLTI};
  assign is_load  = opcode inside {OP_LB, OP_LH, OP_LW,
                                   OP_LBU, OP_LHU, OP_LWU};
  assign is_store = opcode inside {OP_SB, OP_SH, OP_SW};
  assign is_j     = opcode == OP_J;
  assign is_jal   = opcode == OP_JAL;
  assign is_beq   = opcode == OP_BEQ;
  assign is_bne   = opcode == OP_BNE;
  assign is_halt  = i_instruction == HALT_INSTR;

  ctrl_t ctrl;

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (1'b1)
      is_r_alu: begin
        ctrl.wb_write   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.alu_op     = ALU_OP_R;
      end
      is_ialu: begin
        ctrl.wb_write   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_OP_I;
      end
      is_load: begin
        ctrl.wb_write     = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.mem_unsigned = opcode inside {OP_LBU, OP_LHU, OP_LWU};
        ctrl.bhw          = bhw_of(opcode);
        ctrl.alu_src      = 1'b1;
        ctrl.alu_op       = ALU_OP_ADD;
      end
      is_store: begin
        ctrl.mem_write = 1'b1;
        ctrl.bhw       = bhw_of(opcode);
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      is_jal: begin
        ctrl.wb_write   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      is_jalr: begin
        ctrl.wb_write   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b1;
      end
      default: ;
    endcase
  end

  logic [NB_DATA-1:0] br_target;
  logic [NB_DATA-1:0] target;
  logic               take;
  logic               gate;

  assign br_target = i_pc4 + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    take   = 1'b0;
    target = '0;
    unique case (1'b1)
      is_j, is_jal: begin
        take   = 1'b1;
        target = {i_pc4[31:28], i_instruction[25:0], 2'b00};
      end
      is_jr, is_jalr: begin
        take   = 1'b1;
        target = rs_data;
      end
      is_beq: begin
        take   = rs_data == rt_data;
        target = br_target;
      end
      is_bne: begin
        take   = rs_data != rt_data;
        target = br_target;
      end
      default: ;
    endcase
  end

  // a stalled instruction becomes a bubble and must not redirect fetch
  assign gate        = ~i_stall & ~i_reset;
  assign o_jump      = take & gate;
  assign o_jump_addr = o_jump ? target : '0;
  assign o_halt      = is_halt & gate;

  logic  link;
  ctrl_t ctrl_q;

  assign link = is_jal | is_jalr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_RA        <= '0;
      o_RB        <= '0;
      o_rs        <= '0;
      o_rt        <= '0;
      o_rd        <= '0;
      o_shamt     <= '0;
      o_funct     <= '0;
      o_opcode    <= '0;
      o_inmediato <= '0;
      ctrl_q      <= CTRL_NOP;
    end else begin
      o_RA        <= link ? i_pc4 : rs_data;
      o_RB        <= link ? '0 : rt_data;
      o_rs        <= rs;
      o_rt        <= is_jal ? 5'd31 : rt;
      o_rd        <= rd;
      o_shamt     <= shamt;
      o_funct     <= funct;
      o_opcode    <= opcode;
      o_inmediato <= imm;
      ctrl_q      <= i_stall ? CTRL_NOP : ctrl;
    end
  end

  assign o_WB_write           = ctrl_q.wb_write;
  assign o_WB_mem_to_reg      = ctrl_q.mem_to_reg;
  assign o_MEM_read           = ctrl_q.mem_read;
  assign o_MEM_write          = ctrl_q.mem_write;
  assign o_MEM_unsigned       = ctrl_q.mem_unsigned;
  assign o_MEM_byte_half_word = ctrl_q.bhw;
  assign o_EX_alu_src         = ctrl_q.alu_src;
  assign o_EX_reg_dst         = ctrl_q.reg_dst;
  assign o_EX_alu_op          = ctrl_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: reference model + literals.
module tb_instruction_decode;

  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_JAL  = 6'b000011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_XORI = 6'b001110;
  localparam logic [5:0] T_LB   = 6'b100000;
  localparam logic [5:0] T_LH   = 6'b100001;
  localparam logic [5:0] T_LBU  = 6'b100100;
  localparam logic [5:0] T_LHU  = 6'b100101;
  localparam logic [5:0] T_LWU  = 6'b100111;
  localparam logic [5:0] T_SB   = 6'b101000;
  localparam logic [5:0] T_SH   = 6'b101001;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;

  localparam int K_NOP = 0, K_RALU = 1, K_IALU = 2, K_LOAD = 3;
  localparam int K_STORE = 4, K_J = 5, K_JAL = 6, K_JR = 7;
  localparam int K_JALR = 8, K_BEQ = 9, K_BNE = 10, K_HALT = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc4, instr, wdata;
  logic        we, stall;
  logic [4:0]  wreg;

  logic [31:0] o_RA, o_RB, o_jump_addr;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct, o_opcode;
  logic [15:0] o_inmediato;
  logic        o_WB_write, o_WB_mem_to_reg, o_MEM_read;
  logic        o_MEM_write, o_MEM_unsigned;
  logic [1:0]  o_MEM_byte_half_word, o_EX_alu_op;
  logic        o_EX_alu_src, o_EX_reg_dst, o_jump, o_halt;
`ifdef DEBUG_REGFILE_EN
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
`endif

  always #5 clk = ~clk;

  instruction_decode dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_pc4                (pc4),
    .i_instruction        (instr),
    .i_write_enable_WB    (we),
    .i_register_WB        (wreg),
    .i_data_WB            (wdata),
    .i_stall              (stall),
    .o_RA                 (o_RA),
    .o_RB                 (o_RB),
    .o_rs                 (o_rs),
    .o_rt                 (o_rt),
    .o_rd                 (o_rd),
    .o_shamt              (o_shamt),
    .o_funct              (o_funct),
    .o_opcode             (o_opcode),
    .o_inmediato          (o_inmediato),
    .o_WB_write           (o_WB_write),
    .o_WB_mem_to_reg      (o_WB_mem_to_reg),
    .o_MEM_read           (o_MEM_read),
    .o_MEM_write          (o_MEM_write),
    .o_MEM_unsigned       (o_MEM_unsigned),
    .o_MEM_byte_half_word (o_MEM_byte_half_word),
    .o_EX_alu_src         (o_EX_alu_src),
    .o_EX_reg_dst         (o_EX_reg_dst),
    .o_EX_alu_op          (o_EX_alu_op),
    .o_jump_addr          (o_jump_addr),
    .o_jump               (o_jump),
    .o_halt               (o_halt)
`ifdef DEBUG_REGFILE_EN
    ,
    .i_debug_addr         (dbg_addr),
    .o_debug_data         (dbg_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] ra, rb;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn, op;
    logic [15:0] imm;
    logic [10:0] ctl;
  } exp_t;

  logic [31:0] mregs [32];
  exp_t        exp_q;
  logic        started = 1'b0;

  function automatic int klass(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'hFFFF_FFFF) return K_HALT;
    if (op == 6'd0) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                     6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
                     6'h04, 6'h06, 6'h07}) return K_RALU;
      if (fn == F_JR) return K_JR;
      if (fn == F_JALR) return K_JALR;
      return K_NOP;
    end
    if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A})
      return K_IALU;
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27})
      return K_LOAD;
    if (op inside {6'h28, 6'h29, 6'h2B}) return K_STORE;
    if (op == T_J) return K_J;
    if (op == T_JAL) return K_JAL;
    if (op == T_BEQ) return K_BEQ;
    if (op == T_BNE) return K_BNE;
    return K_NOP;
  endfunction

  // {wb, m2r, mread, mwrite, uns, bhw[2], alu_src, reg_dst, alu_op[2]}
  function automatic logic [10:0] ctl_of(input int k,
                                         input logic [5:0] op);
    logic [1:0] b;
    logic       u;
    if (op == T_LB || op == T_LBU || op == T_SB) b = 2'b00;
    else if (op == T_LH || op == T_LHU || op == T_SH) b = 2'b01;
    else b = 2'b11;
    u = op == T_LBU || op == T_LHU || op == T_LWU;
    case (k)
      K_RALU:  return {5'b11000, 2'b00, 2'b01, 2'b10};
      K_IALU:  return {5'b11000, 2'b00, 2'b10, 2'b11};
      K_LOAD:  return {4'b1010, u, b, 2'b10, 2'b00};
      K_STORE: return {5'b00010, b, 2'b10, 2'b00};
      K_JAL:   return {5'b11000, 2'b00, 2'b00, 2'b00};
      K_JALR:  return {5'b11000, 2'b00, 2'b01, 2'b00};
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [31:0] rdm(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wreg == a) return wdata;
    return mregs[a];
  endfunction

  function automatic exp_t predict_regs();
    exp_t e;
    int   k;
    logic lnk;
    k     = klass(instr);
    lnk   = k == K_JAL || k == K_JALR;
    e.ra  = lnk ? pc4 : rdm(instr[25:21]);
    e.rb  = lnk ? 32'd0 : rdm(instr[20:16]);
    e.rs  = instr[25:21];
    e.rt  = k == K_JAL ? 5'd31 : instr[20:16];
    e.rd  = instr[15:11];
    e.sh  = instr[10:6];
    e.fn  = instr[5:0];
    e.op  = instr[31:26];
    e.imm = instr[15:0];
    e.ctl = stall ? 11'd0 : ctl_of(k, instr[31:26]);
    return e;
  endfunction

  function automatic void predict_comb(output logic j,
                                       output logic [31:0] a,
                                       output logic h);
    int          k, off;
    logic [31:0] s, t, tgt;
    k   = klass(instr);
    s   = rdm(instr[25:21]);
    t   = rdm(instr[20:16]);
    off = int'($signed(instr[15:0])) * 4;
    j   = 1'b0;
    tgt = 32'd0;
    case (k)
      K_J, K_JAL: begin
        j = 1'b1;
        tgt = {pc4[31:28], 28'd0} + {4'd0, instr[25:0], 2'b00};
      end
      K_JR, K_JALR: begin j = 1'b1; tgt = s; end
      K_BEQ: begin j = s == t; tgt = pc4 + 32'(off); end
      K_BNE: begin j = s != t; tgt = pc4 + 32'(off); end
      default: ;
    endcase
    h = k == K_HALT;
    if (stall || rst) begin j = 1'b0; h = 1'b0; end
    a = j ? tgt : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      for (int i = 0; i < 32; i++) mregs[i] <= 32'(i);
    end else begin
      exp_q <= predict_regs();
      if (we && wreg != 5'd0) mregs[wreg] <= wdata;
    end
  end

  logic        cj, ch;
  logic [31:0] ca;

  always @(negedge clk) begin
    if (started) begin
      predict_comb(cj, ca, ch);
      chk("ra", o_RA, exp_q.ra);
      chk("rb", o_RB, exp_q.rb);
      chk("rs", 32'(o_rs), 32'(exp_q.rs));
      chk("rt", 32'(o_rt), 32'(exp_q.rt));
      chk("rd", 32'(o_rd), 32'(exp_q.rd));
      chk("shamt", 32'(o_shamt), 32'(exp_q.sh));
      chk("funct", 32'(o_funct), 32'(exp_q.fn));
      chk("opcode", 32'(o_opcode), 32'(exp_q.op));
      chk("imm", 32'(o_inmediato), 32'(exp_q.imm));
      chk("ctl", 32'({o_WB_write, o_WB_mem_to_reg, o_MEM_read,
                      o_MEM_write, o_MEM_unsigned,
                      o_MEM_byte_half_word, o_EX_alu_src,
                      o_EX_reg_dst, o_EX_alu_op}), 32'(exp_q.ctl));
      chk("jump", 32'(o_jump), 32'(cj));
      chk("jump_addr", o_jump_addr, ca);
      chk("halt", 32'(o_halt), 32'(ch));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input int s, t, d, sh,
                                        input logic [5:0] fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
                                        input int s, t,
                                        input logic [15:0] im);
    return {op, 5'(s), 5'(t), im};
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] p4,
                      input logic st, input logic w,
                      input logic [4:0] wr, input logic [31:0] wd);
    #1;
    instr = ins; pc4 = p4; stall = st;
    we = w; wreg = wr; wdata = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1; we = 1'b0; stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] tmpl [16];
  logic [31:0] rnd;

  initial begin
    rst = 1'b1;
    instr = {T_J, 26'd10}; pc4 = 32'd4;
    stall = 1'b0; we = 1'b0; wreg = 5'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("lit_rst_ra", o_RA, 32'd0);
    chk("lit_rst_wb", 32'(o_WB_write), 32'd0);
    chk("lit_rst_jump", 32'(o_jump), 32'd0);
    chk("lit_rst_jaddr", o_jump_addr, 32'd0);
    started = 1'b1;
    #1 rst = 1'b0;

    step(enc_r(5, 6, 31, 0, F_ADD), 32'd8, 0, 0, 0, 0);
    chk("lit_add_ra", o_RA, 32'd5);
    chk("lit_add_rb", o_RB, 32'd6);
    chk("lit_add_funct", 32'(o_funct), 32'h20);
    chk("lit_add_ctl", 32'({o_WB_write, o_WB_mem_to_reg,
                            o_EX_reg_dst, o_EX_alu_src, o_EX_alu_op}),
        32'b111010);
    chk("lit_add_jump", 32'(o_jump), 32'd0);

    step(enc_i(T_XORI, 1, 2, 16'd4), 32'd12, 0, 0, 0, 0);
    chk("lit_xori", 32'({o_EX_alu_src, o_EX_reg_dst, o_EX_alu_op}),
        32'b1011);
    chk("lit_xori_imm", 32'(o_inmediato), 32'd4);

    step(enc_i(T_LHU, 1, 2, 16'd8), 32'd16, 0, 0, 0, 0);
    chk("lit_lhu", 32'({o_MEM_read, o_WB_mem_to_reg,
                        o_MEM_byte_half_word, o_MEM_unsigned,
                        o_EX_alu_op}), 32'b1001100);

    step(enc_i(T_SW, 3, 4, 16'd8), 32'd20, 0, 0, 0, 0);
    chk("lit_sw", 32'({o_MEM_write, o_WB_write,
                       o_MEM_byte_half_word, o_MEM_unsigned}),
        32'b10110);

    step(enc_i(T_SW, 3, 4, 16'd8), 32'd20, 1, 0, 0, 0);
    chk("lit_stall_ctl", 32'({o_WB_write, o_MEM_write}), 32'd0);
    chk("lit_stall_ra", o_RA, 32'd3);

    step(enc_r(5, 6, 31, 0, F_ADD), 32'd8, 0, 1, 5'd5, 32'd6);
    chk("lit_bypass_ra", o_RA, 32'd6);

    step(enc_r(5, 0, 0, 0, F_JR), 32'd8, 0, 0, 0, 0);
    chk("lit_jr_jump", 32'(o_jump), 32'd1);
    chk("lit_jr_addr", o_jump_addr, 32'd6);
    chk("lit_jr_wb", 32'(o_WB_write), 32'd0);

    step({T_J, 26'd10}, 32'd4, 0, 0, 0, 0);
    chk("lit_j_addr", o_jump_addr, 32'h28);

    step({T_JAL, 26'd10}, 32'd4, 0, 0, 0, 0);
    chk("lit_jal", 32'({o_jump, o_WB_write, o_EX_reg_dst}), 32'b110);
    chk("lit_jal_ra", o_RA, 32'd4);
    chk("lit_jal_rt", 32'(o_rt), 32'd31);

    step(enc_r(5, 0, 31, 0, F_JALR), 32'd4, 0, 0, 0, 0);
    chk("lit_jalr_ra", o_RA, 32'd4);
    chk("lit_jalr_rd", 32'(o_rd), 32'd31);
    chk("lit_jalr_dst", 32'(o_EX_reg_dst), 32'd1);

    step(enc_r(5, 0, 0, 0, F_JR), 32'd8, 1, 0, 0, 0);
    chk("lit_jr_stall", 32'(o_jump), 32'd0);

    step(enc_r(0, 5, 1, 0, F_ADD), 32'd8, 0, 1, 5'd0, 32'd55);
    chk("lit_r0_bypass", o_RA, 32'd0);
    step(enc_r(0, 5, 1, 0, F_ADD), 32'd8, 0, 0, 0, 0);
    chk("lit_r0_keep", o_RA, 32'd0);

    do_reset();
    step(enc_i(T_BNE, 5, 6, 16'd4), 32'd4, 0, 0, 0, 0);
    chk("lit_bne_jump", 32'(o_jump), 32'd1);
    chk("lit_bne_addr", o_jump_addr, 32'd20);
    step(enc_i(T_BEQ, 5, 6, 16'd4), 32'd4, 0, 0, 0, 0);
    chk("lit_beq_jump", 32'(o_jump), 32'd0);
    chk("lit_beq_addr", o_jump_addr, 32'd0);
    step(enc_i(T_BEQ, 0, 0, 16'hFFFF), 32'd8, 0, 0, 0, 0);
    chk("lit_beq_back", o_jump_addr, 32'd4);
    step(32'hFFFF_FFFF, 32'd8, 0, 0, 0, 0);
    chk("lit_halt", 32'(o_halt), 32'd1);
    chk("lit_halt_ctl", 32'(o_WB_write), 32'd0);
    step(32'hFFFF_FFFF, 32'd8, 1, 0, 0, 0);
    chk("lit_halt_stall", 32'(o_halt), 32'd0);
    step(enc_i(6'b111110, 1, 2, 16'd3), 32'd8, 0, 0, 0, 0);
    chk("lit_unknown", 32'({o_WB_write, o_EX_alu_op}), 32'd0);

    tmpl = '{32'h0000_0020, 32'h0000_0022, 32'h0000_0004,
             32'h0000_003F, 32'h2000_0000, 32'h3C00_0000,
             32'h8000_0000, 32'h8400_0000, 32'h9000_0000,
             32'h9C00_0000, 32'hA000_0000, 32'hA400_0000,
             32'h1000_0000, 32'h1400_0000, 32'h0000_0008,
             32'hFFFF_FFFF};
    for (int n = 0; n < 48; n++) begin
      rnd = $urandom;
      instr = tmpl[$urandom_range(0, 15)];
      rnd = rnd & 32'h0003_FFFF;
      step(instr[31:26] == 6'd0 ? (instr | (rnd & 32'h03FF_FFC0))
                                : (instr | (rnd & 32'h03FF_FFFF)),
           $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
